// File: rtl/mem_port_arbiter.sv
// Shares the single-port Memoria between the CPU datapath and a DMA/debug requester.
// CPU has fixed priority, DMA is protected by a starvation counter and may lock bounded bursts.
module mem_port_arbiter #(
   parameter int MEM_LAT   = 1,
   parameter int MAX_WAIT  = 8,
   parameter int MAX_BURST = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_wr,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic        dma_last,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  owner
);

   typedef enum logic {ARB, DMA_LOCK} state_t;

   localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT);
   localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

   state_t      state;
   state_t      state_next;
   logic [7:0]  starve_cnt;
   logic [7:0]  starve_next;
   logic [7:0]  burst_cnt;
   logic [7:0]  burst_next;
   logic [31:0] last_addr;
   logic        tag_valid_in;
   logic        tag_dma_in;
   logic        tag_valid_out;
   logic        tag_dma_out;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state      <= ARB;
         starve_cnt <= '0;
         burst_cnt  <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         burst_cnt  <= burst_next;
      end
   end

   // Grant decision and lock bookkeeping; nothing is granted while Reset is held low.
   always_comb begin
      state_next  = state;
      starve_next = starve_cnt;
      burst_next  = burst_cnt;
      cpu_gnt     = 1'b0;
      dma_gnt     = 1'b0;
      if (Reset) begin
         case (state)
            ARB: begin
               if (cpu_req && dma_req) begin
                  if (starve_cnt >= WAIT_LIM) begin
                     dma_gnt = 1'b1;
                  end else begin
                     cpu_gnt     = 1'b1;
                     starve_next = starve_cnt + 8'd1;
                  end
               end else if (cpu_req) begin
                  cpu_gnt = 1'b1;
               end else if (dma_req) begin
                  dma_gnt = 1'b1;
               end
               if (dma_gnt) begin
                  starve_next = '0;
                  if (!dma_last && (BURST_LIM > 8'd1)) begin
                     state_next = DMA_LOCK;
                     burst_next = 8'd1;
                  end
               end
            end
            DMA_LOCK: begin
               dma_gnt = dma_req;
               if (dma_gnt) begin
                  burst_next = burst_cnt + 8'd1;
                  if (dma_last || (burst_next == BURST_LIM)) begin
                     state_next = ARB;
                  end
               end
            end
            default: state_next = ARB;
         endcase
      end
   end

   // Memoria mux; the address bus parks on the last granted address when idle.
   always_comb begin
      mem_addr  = last_addr;
      mem_wr    = 1'b0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wr    = cpu_wr;
         mem_wdata = cpu_wdata;
      end else if (dma_gnt) begin
         mem_addr  = dma_addr;
         mem_wr    = dma_wr;
         mem_wdata = dma_wdata;
      end
   end

   assign owner        = {dma_gnt, cpu_gnt};
   assign tag_valid_in = (cpu_gnt && !cpu_wr) || (dma_gnt && !dma_wr);
   assign tag_dma_in   = dma_gnt;

   // Read tags travel MEM_LAT-1 stages, the rvalid/rdata registers form the final stage.
   if (MEM_LAT == 1) begin : g_tag_direct
      assign tag_valid_out = tag_valid_in;
      assign tag_dma_out   = tag_dma_in;
   end else begin : g_tag_pipe
      logic [MEM_LAT-2:0] valid_pipe;
      logic [MEM_LAT-2:0] dma_pipe;

      always_ff @(posedge Clk) begin
         if (!Reset) begin
            valid_pipe <= '0;
            dma_pipe   <= '0;
         end else begin
            valid_pipe[0] <= tag_valid_in;
            dma_pipe[0]   <= tag_dma_in;
            for (int i = 1; i < MEM_LAT - 1; i++) begin
               valid_pipe[i] <= valid_pipe[i-1];
               dma_pipe[i]   <= dma_pipe[i-1];
            end
         end
      end

      assign tag_valid_out = valid_pipe[MEM_LAT-2];
      assign tag_dma_out   = dma_pipe[MEM_LAT-2];
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         last_addr  <= '0;
         cpu_rvalid <= 1'b0;
         dma_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
      end else begin
         if (cpu_gnt || dma_gnt) begin
            last_addr <= mem_addr;
         end
         cpu_rvalid <= tag_valid_out && !tag_dma_out;
         dma_rvalid <= tag_valid_out && tag_dma_out;
         if (tag_valid_out && !tag_dma_out) begin
            cpu_rdata <= mem_rdata;
         end
         if (tag_valid_out && tag_dma_out) begin
            dma_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants,
// the Memoria bus and tagged read returns every cycle.
module tb_mem_port_arbiter;

   localparam int MEM_LAT   = 2;
   localparam int MAX_WAIT  = 8;
   localparam int MAX_BURST = 16;
   localparam int PHASE_LEN = 400;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dma_req, dma_wr, dma_last, dma_gnt, dma_rvalid;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wr;
   logic [1:0]  owner;

   always #5 Clk = ~Clk;

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .owner(owner)
   );

   // Memoria stand-in: one register stage (MEM_LAT-1), preloaded on the first edge.
   logic [31:0] tb_mem [64];
   logic [31:0] rd_q;
   logic        mem_loaded = 1'b0;

   always @(posedge Clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 64; i++) tb_mem[i] <= 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
         mem_loaded <= 1'b1;
      end else begin
         rd_q <= tb_mem[mem_addr[7:2]];
         if (mem_wr) tb_mem[mem_addr[7:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = rd_q;

   typedef struct {
      int          due;
      bit          to_dma;
      logic [31:0] data;
   } rd_t;

   rd_t         rq[$];
   rd_t         ent;
   logic [31:0] model_mem [64];
   bit          m_locked;
   int          m_waited;
   int          m_beats;
   logic [31:0] m_last_addr;
   logic [31:0] exp_crdata, exp_drdata, exp_addr;
   bit          exp_cv, exp_dv, exp_wr;
   int          g;
   int          cyc;
   int          check_count = 0;
   int          error_count = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      check_count++;
      if (got !== expv) begin
         error_count++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   task automatic applyStimulus(input int phase);
      Reset     = (phase != 1 && $urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      cpu_addr  = {26'h0, 4'($urandom), 2'b00};
      dma_addr  = {26'h0, 4'($urandom), 2'b00};
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
      cpu_wr    = 1'($urandom);
      dma_wr    = 1'($urandom);
      case (phase)
         0: begin
            cpu_req  = 1'($urandom);
            dma_req  = 1'($urandom);
            dma_last = 1'($urandom);
         end
         1: begin
            cpu_req  = 1'b1;
            dma_req  = 1'b1;
            dma_wr   = 1'b0;
            dma_last = 1'b1;
         end
         2: begin
            cpu_req  = 1'b1;
            dma_req  = ($urandom_range(0, 3) != 0);
            dma_last = ($urandom_range(0, 5) == 0);
         end
         3: begin
            cpu_req  = 1'($urandom);
            dma_req  = 1'b1;
            dma_last = 1'b0;
         end
         default: begin
            cpu_req  = (cyc % 2 == 0) || ($urandom_range(0, 3) == 0);
            dma_req  = (cyc % 2 == 1) || ($urandom_range(0, 3) == 0);
            cpu_addr = 32'h0;
            dma_addr = 32'h4;
            cpu_wr   = ($urandom_range(0, 7) == 0);
            dma_wr   = ($urandom_range(0, 7) == 0);
            dma_last = 1'b1;
         end
      endcase
   endtask

   initial begin
      Reset = 1'b0;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0; dma_last = 1'b0;
      for (int i = 0; i < 64; i++) model_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      m_locked = 0; m_waited = 0; m_beats = 0; m_last_addr = '0;
      exp_crdata = '0; exp_drdata = '0;
      cyc = 0;
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      checkOutput("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
      checkOutput("rst_dma_rdata", dma_rdata, 32'd0);
      checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      checkOutput("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      checkOutput("rst_owner", 32'(owner), 32'd0);
      checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);

      for (int phase = 0; phase < 5; phase++) begin
         for (int k = 0; k < PHASE_LEN; k++) begin
            exp_cv = 0;
            exp_dv = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
               ent = rq.pop_front();
               if (ent.to_dma) begin exp_dv = 1; exp_drdata = ent.data; end
               else begin exp_cv = 1; exp_crdata = ent.data; end
            end
            checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
            checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(exp_dv));
            checkOutput("cpu_rdata", cpu_rdata, exp_crdata);
            checkOutput("dma_rdata", dma_rdata, exp_drdata);

            applyStimulus(phase);
            #1;

            g = 0;
            if (Reset) begin
               if (m_locked) g = dma_req ? 2 : 0;
               else if (cpu_req && dma_req) g = (m_waited >= MAX_WAIT) ? 2 : 1;
               else if (cpu_req) g = 1;
               else if (dma_req) g = 2;
            end
            exp_addr = (g == 1) ? cpu_addr : (g == 2) ? dma_addr : m_last_addr;
            exp_wr   = (g == 1) ? cpu_wr : (g == 2) ? dma_wr : 1'b0;
            checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(g == 1));
            checkOutput("dma_gnt", 32'(dma_gnt), 32'(g == 2));
            checkOutput("owner", 32'(owner), 32'(g));
            checkOutput("mem_wr", 32'(mem_wr), 32'(exp_wr));
            checkOutput("mem_addr", mem_addr, exp_addr);
            if (g != 0) checkOutput("mem_wdata", mem_wdata, (g == 1) ? cpu_wdata : dma_wdata);

            if (!Reset) begin
               m_locked = 0; m_waited = 0; m_beats = 0; m_last_addr = '0;
               rq.delete();
               exp_crdata = '0; exp_drdata = '0;
            end else begin
               if (g != 0) begin
                  m_last_addr = exp_addr;
                  if (exp_wr) model_mem[exp_addr[7:2]] = (g == 1) ? cpu_wdata : dma_wdata;
                  else rq.push_back('{cyc + MEM_LAT, (g == 2), model_mem[exp_addr[7:2]]});
               end
               if (g == 1 && dma_req && m_waited < MAX_WAIT) m_waited++;
               if (g == 2) begin
                  m_waited = 0;
                  if (!m_locked) begin
                     if (!dma_last && MAX_BURST > 1) begin m_locked = 1; m_beats = 1; end
                  end else if (dma_last) begin
                     m_locked = 0;
                  end else begin
                     m_beats++;
                     if (m_beats >= MAX_BURST) m_locked = 0;
                  end
               end
            end

            @(posedge Clk);
            #1;
            cyc++;
         end
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
